m_bcd_updown_counter: RTL

- Multi-digit BCD counter that counts up or down. Each digit has its own rollover limit, so one instance covers mm:ss, hh:mm or plain decimal counts.
- Adds over the fixed-modulo counters: parallel load, synchronous clear, wrap or saturate mode, and a sticky done flag for countdown use.
- Sits between the 1 Hz tick or debounced-switch logic and the 7-segment decoders in the kitchen timer datapath.
- Chains to further instances through c_in/c_out.

---
 rtl/m_bcd_updown_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/m_bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a per-digit rollover limit, parallel load,
// synchronous clear, wrap/saturate end behaviour and a sticky countdown-done flag.
module m_bcd_updown_counter #(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MAX = 16'h5959,
  parameter bit                  WRAP      = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  c_in,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  c_out,
  output logic                  zero,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    q_reg;
  logic [W-1:0]    q_next;
  logic            done_reg;
  logic            done_next;

  logic [W-1:0]    up_val;
  logic [W-1:0]    dn_val;
  logic [W-1:0]    load_clamped;

  // low_max[i] / low_zero[i]: every digit below i sits at its max / at zero.
  logic [DIGITS:0] low_max;
  logic [DIGITS:0] low_zero;
  logic            all_max;
  logic            all_zero;

  assign low_max[0]  = 1'b1;
  assign low_zero[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] dmax;
      logic [3:0] lv;

      assign digit = q_reg[4*gi +: 4];
      assign dmax  = DIGIT_MAX[4*gi +: 4];
      assign lv    = load_val[4*gi +: 4];

      assign low_max[gi+1]  = low_max[gi]  & (digit == dmax);
      assign low_zero[gi+1] = low_zero[gi] & (digit == 4'd0);

      // Per-nibble stepping only; no binary carry ever crosses a digit boundary.
      assign up_val[4*gi +: 4] = !low_max[gi]      ? digit :
                                 (digit == dmax)   ? 4'd0  : digit + 4'd1;
      assign dn_val[4*gi +: 4] = !low_zero[gi]     ? digit :
                                 (digit == 4'd0)   ? dmax  : digit - 4'd1;

      // dmax is at most 9, so A..F nibbles are caught by the same compare.
      assign load_clamped[4*gi +: 4] = (lv > dmax) ? dmax : lv;
    end
  endgenerate

  assign all_max  = low_max[DIGITS];
  assign all_zero = low_zero[DIGITS];

  always_comb begin
    q_next    = q_reg;
    done_next = done_reg;
    if (clear) begin
      q_next    = '0;
      done_next = 1'b0;
    end else if (load) begin
      q_next    = load_clamped;
      done_next = 1'b0;
    end else if (c_in) begin
      if (up) begin
        if (!all_max || WRAP) begin
          q_next = up_val;
        end
      end else begin
        if (!all_zero || WRAP) begin
          q_next = dn_val;
          // Only a real transition from nonzero to zero completes a countdown.
          if (!all_zero && (dn_val == '0)) begin
            done_next = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      q_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      done_reg <= done_next;
    end
  end

  assign q     = q_reg;
  assign done  = done_reg;
  assign zero  = all_zero;
  assign c_out = c_in & ~clear & ~load & n_reset & (up ? all_max : all_zero);

endmodule
